// File: rtl/big_core_pkg.sv
// Shared Q103H memory-stage types and the CR/VGA address map used by the
// data-memory request front end and its region decoder.
package big_core_pkg;

    localparam logic [31:0] CR_BASE       = 32'h00FE_0000;
    localparam logic [31:0] CR_TOP        = 32'h00FF_0000;
    localparam logic [31:0] VGA_BASE      = 32'h00FF_0000;
    localparam logic [31:0] VGA_TOP       = 32'h0100_0000;
    localparam int          STALL_TIMEOUT = 1024;

    typedef struct packed {
        logic [31:0] Address;
        logic [31:0] WrData;
        logic [3:0]  ByteEn;
        logic        WrEn;
        logic        RdEn;
    } t_core2mem_req;

    typedef struct packed {
        logic MatchCrRegion;
        logic MatchVgaRegion;
    } t_dmem_region;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } t_dmem_req_st;

endpackage

// File: rtl/d_mem_region_decode.sv
// Combinational byte-address to CR / VGA region decode; any address outside
// both windows belongs to the cache.
module d_mem_region_decode
    import big_core_pkg::*;
#(
    parameter logic [31:0] CR_BASE_P  = CR_BASE,
    parameter logic [31:0] CR_TOP_P   = CR_TOP,
    parameter logic [31:0] VGA_BASE_P = VGA_BASE,
    parameter logic [31:0] VGA_TOP_P  = VGA_TOP
) (
    input  logic [31:0]  Address_i,
    output t_dmem_region Region_o
);

    always_comb begin
        Region_o.MatchCrRegion  = (Address_i >= CR_BASE_P)  && (Address_i < CR_TOP_P);
        Region_o.MatchVgaRegion = (Address_i >= VGA_BASE_P) && (Address_i < VGA_TOP_P);
    end

endmodule

// File: rtl/d_mem_req_ctrl.sv
// Q103H data-memory request front end: routes core requests to CR, VGA or the
// d_cache, holds cache requests under back-pressure and tracks stall cycles.
module d_mem_req_ctrl
    import big_core_pkg::*;
#(
    parameter logic [31:0] CR_BASE_P       = CR_BASE,
    parameter logic [31:0] CR_TOP_P        = CR_TOP,
    parameter logic [31:0] VGA_BASE_P      = VGA_BASE,
    parameter logic [31:0] VGA_TOP_P       = VGA_TOP,
    parameter int          STALL_TIMEOUT_P = STALL_TIMEOUT
) (
    input  logic          Clock,
    input  logic          Rst,
    input  t_core2mem_req Core2DmemReqQ103H,
    input  logic          CacheReady,
    output t_core2mem_req Core2CacheReqQ103H,
    output logic          Core2CacheValidQ103H,
    output logic          CRMemWrEnQ103H,
    output logic          CRMemRdEnQ103H,
    output logic          VgaMemWrEnQ103H,
    output logic          VgaMemRdEnQ103H,
    output t_dmem_region  MatchDmemRegionQ103H,
    output logic          DMemReady,
    output logic [31:0]   StallCycleCnt,
    output logic          StallTimeout
);

    localparam int             CW     = $clog2(STALL_TIMEOUT_P + 1);
    localparam logic [CW-1:0]  TO_M1  = CW'(STALL_TIMEOUT_P - 1);

    t_dmem_req_st  state_q, state_d;
    t_core2mem_req hold_req_q;
    logic          hold_en;
    logic [31:0]   stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] consec_q, consec_d;
    logic          timeout_q, timeout_d;
    t_dmem_region  region;
    logic          req_v;
    logic          cache_req;

    // In STALL the decode follows the held request, which is always cache.
    d_mem_region_decode #(
        .CR_BASE_P  (CR_BASE_P),
        .CR_TOP_P   (CR_TOP_P),
        .VGA_BASE_P (VGA_BASE_P),
        .VGA_TOP_P  (VGA_TOP_P)
    ) u_region_decode (
        .Address_i (state_q == STALL ? hold_req_q.Address : Core2DmemReqQ103H.Address),
        .Region_o  (region)
    );

    assign req_v     = Core2DmemReqQ103H.WrEn | Core2DmemReqQ103H.RdEn;
    assign cache_req = req_v & ~region.MatchCrRegion & ~region.MatchVgaRegion;

    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d              = state_q;
        hold_en              = 1'b0;
        Core2CacheReqQ103H   = '0;
        Core2CacheValidQ103H = 1'b0;
        CRMemWrEnQ103H       = 1'b0;
        CRMemRdEnQ103H       = 1'b0;
        VgaMemWrEnQ103H      = 1'b0;
        VgaMemRdEnQ103H      = 1'b0;
        MatchDmemRegionQ103H = '0;
        DMemReady            = 1'b1;
        case (state_q)
            IDLE: begin
                MatchDmemRegionQ103H = region;
                CRMemWrEnQ103H       = region.MatchCrRegion  & Core2DmemReqQ103H.WrEn;
                CRMemRdEnQ103H       = region.MatchCrRegion  & Core2DmemReqQ103H.RdEn;
                VgaMemWrEnQ103H      = region.MatchVgaRegion & Core2DmemReqQ103H.WrEn;
                VgaMemRdEnQ103H      = region.MatchVgaRegion & Core2DmemReqQ103H.RdEn;
                if (cache_req) begin
                    Core2CacheValidQ103H = 1'b1;
                    Core2CacheReqQ103H   = Core2DmemReqQ103H;
                    if (!CacheReady) begin
                        DMemReady = 1'b0;
                        hold_en   = 1'b1;
                        state_d   = STALL;
                    end
                end
            end
            STALL: begin
                // The core is frozen; only the captured request is presented.
                Core2CacheValidQ103H = 1'b1;
                Core2CacheReqQ103H   = hold_req_q;
                DMemReady            = CacheReady;
                if (CacheReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!DMemReady && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;

        consec_d = '0;
        if (!DMemReady) consec_d = (consec_q == TO_M1) ? consec_q : consec_q + 1'b1;

        timeout_d = timeout_q | (~DMemReady & (consec_q == TO_M1));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
            consec_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            consec_q    <= consec_d;
            timeout_q   <= timeout_d;
        end
    end

    // NOTE: the hold register is reset so a request dropped by Rst can never reappear on the cache port.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst)          hold_req_q <= '0;
        else if (hold_en) hold_req_q <= Core2DmemReqQ103H;
    end

    assign StallCycleCnt = stall_cnt_q;
    assign StallTimeout  = timeout_q;

endmodule

// File: tb/tb_d_mem_req_ctrl.sv
// Directed bench for d_mem_req_ctrl: routing, stall hold, write suppression,
// region boundaries, timeout and asynchronous reset.
module tb_d_mem_req_ctrl;
    import big_core_pkg::*;

    logic          Clock;
    logic          Rst;
    t_core2mem_req req;
    logic          cache_ready;
    t_core2mem_req c_req;
    logic          c_valid;
    logic          cr_wr, cr_rd, vga_wr, vga_rd;
    t_dmem_region  match;
    logic          ready;
    logic [31:0]   stall_cnt;
    logic          timeout;

    int n_checks = 0;
    int n_fails  = 0;

    d_mem_req_ctrl dut (
        .Clock                (Clock),
        .Rst                  (Rst),
        .Core2DmemReqQ103H    (req),
        .CacheReady           (cache_ready),
        .Core2CacheReqQ103H   (c_req),
        .Core2CacheValidQ103H (c_valid),
        .CRMemWrEnQ103H       (cr_wr),
        .CRMemRdEnQ103H       (cr_rd),
        .VgaMemWrEnQ103H      (vga_wr),
        .VgaMemRdEnQ103H      (vga_rd),
        .MatchDmemRegionQ103H (match),
        .DMemReady            (ready),
        .StallCycleCnt        (stall_cnt),
        .StallTimeout         (timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock)
        if (!Rst) assert (!(req.WrEn && req.RdEn)) else $error("illegal request: WrEn and RdEn both set");

    function automatic t_core2mem_req mk(input logic [31:0] a, input logic [31:0] d,
                                         input logic wr, input logic rd);
        t_core2mem_req r;
        r.Address = a;
        r.WrData  = d;
        r.ByteEn  = 4'hF;
        r.WrEn    = wr;
        r.RdEn    = rd;
        return r;
    endfunction

    // Drive one cycle's inputs away from the rising edge, then settle.
    task automatic apply(input t_core2mem_req r, input logic cr);
        @(negedge Clock);
        req         = r;
        cache_ready = cr;
        #1;
    endtask

    task automatic test_reset;
        Rst = 1'b1; req = '0; cache_ready = 1'b0;
        #12;
        n_checks++; if (ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready got %b want 1", ready); end
        n_checks++; if ({c_valid, cr_wr, cr_rd, vga_wr, vga_rd, match} !== 7'b0) begin
            n_fails++; $display("FAIL reset_strobes got %b want 0", {c_valid, cr_wr, cr_rd, vga_wr, vga_rd, match}); end
        n_checks++; if (stall_cnt !== 32'd0 || timeout !== 1'b0) begin
            n_fails++; $display("FAIL reset_counters got cnt=%0d to=%b want 0/0", stall_cnt, timeout); end
        n_checks++; if (c_req !== '0) begin n_fails++; $display("FAIL reset_cache_req got %h want 0", c_req); end
        @(negedge Clock);
        Rst = 1'b0;
    endtask

    task automatic test_cr_write;
        apply(mk(32'h00FE_0010, 32'hDEAD_BEEF, 1'b1, 1'b0), 1'b1);
        n_checks++; if ({cr_wr, cr_rd, vga_wr, vga_rd} !== 4'b1000) begin
            n_fails++; $display("FAIL cr_wr_strobes got %b want 1000", {cr_wr, cr_rd, vga_wr, vga_rd}); end
        n_checks++; if (match !== 2'b10) begin n_fails++; $display("FAIL cr_wr_match got %b want 10", match); end
        n_checks++; if (ready !== 1'b1 || c_valid !== 1'b0) begin
            n_fails++; $display("FAIL cr_wr_ready_valid got %b%b want 10", ready, c_valid); end
        apply('0, 1'b1);
        n_checks++; if (cr_wr !== 1'b0) begin n_fails++; $display("FAIL cr_wr_one_cycle got %b want 0", cr_wr); end
    endtask

    task automatic test_vga_read;
        apply(mk(32'h00FF_0042, 32'h0, 1'b0, 1'b1), 1'b0);
        n_checks++; if ({cr_wr, cr_rd, vga_wr, vga_rd} !== 4'b0001) begin
            n_fails++; $display("FAIL vga_rd_strobes got %b want 0001", {cr_wr, cr_rd, vga_wr, vga_rd}); end
        n_checks++; if (match !== 2'b01) begin n_fails++; $display("FAIL vga_rd_match got %b want 01", match); end
        n_checks++; if (ready !== 1'b1 || c_valid !== 1'b0) begin
            n_fails++; $display("FAIL vga_rd_no_stall got %b%b want 10", ready, c_valid); end
        apply('0, 1'b1);
    endtask

    task automatic test_cache_stall;
        t_core2mem_req rd;
        rd = mk(32'h0000_1000, 32'h0, 1'b0, 1'b1);
        apply(rd, 1'b0);
        n_checks++; if (ready !== 1'b0 || c_valid !== 1'b1 || c_req.Address !== 32'h0000_1000) begin
            n_fails++; $display("FAIL stall_c1 got rdy=%b v=%b a=%h want 0/1/00001000", ready, c_valid, c_req.Address); end
        apply(rd, 1'b0);
        n_checks++; if (ready !== 1'b0 || c_req.Address !== 32'h0000_1000 || match !== 2'b00) begin
            n_fails++; $display("FAIL stall_c2 got rdy=%b a=%h m=%b want 0/00001000/00", ready, c_req.Address, match); end
        // Live input changed mid-stall must be ignored.
        apply(mk(32'h5555_0000, 32'h0, 1'b0, 1'b1), 1'b0);
        n_checks++; if (ready !== 1'b0 || c_req.Address !== 32'h0000_1000) begin
            n_fails++; $display("FAIL stall_c3_hold got rdy=%b a=%h want 0/00001000", ready, c_req.Address); end
        apply(rd, 1'b1);
        n_checks++; if (ready !== 1'b1 || c_valid !== 1'b1 || c_req.Address !== 32'h0000_1000) begin
            n_fails++; $display("FAIL stall_accept got rdy=%b v=%b a=%h want 1/1/00001000", ready, c_valid, c_req.Address); end
        apply('0, 1'b1);
        n_checks++; if (ready !== 1'b1 || c_valid !== 1'b0) begin
            n_fails++; $display("FAIL stall_back_idle got rdy=%b v=%b want 1/0", ready, c_valid); end
        n_checks++; if (stall_cnt !== 32'd3) begin n_fails++; $display("FAIL stall_cnt3 got %0d want 3", stall_cnt); end
    endtask

    task automatic test_stall_suppress;
        t_core2mem_req crw;
        int wr_pulses;
        crw = mk(32'h00FE_0020, 32'h1234_5678, 1'b1, 1'b0);
        wr_pulses = 0;
        apply(mk(32'h0000_2000, 32'hCAFE_0000, 1'b1, 1'b0), 1'b0);
        wr_pulses += int'(cr_wr);
        apply(crw, 1'b0);
        wr_pulses += int'(cr_wr);
        n_checks++; if (cr_wr !== 1'b0 || ready !== 1'b0 || c_req.Address !== 32'h0000_2000) begin
            n_fails++; $display("FAIL suppress_stall got crwr=%b rdy=%b a=%h want 0/0/00002000", cr_wr, ready, c_req.Address); end
        apply(crw, 1'b1);
        wr_pulses += int'(cr_wr);
        n_checks++; if (cr_wr !== 1'b0 || ready !== 1'b1 || match !== 2'b00) begin
            n_fails++; $display("FAIL suppress_exit got crwr=%b rdy=%b m=%b want 0/1/00", cr_wr, ready, match); end
        apply(crw, 1'b1);
        wr_pulses += int'(cr_wr);
        n_checks++; if (cr_wr !== 1'b1 || match !== 2'b10 || c_valid !== 1'b0) begin
            n_fails++; $display("FAIL suppress_issue got crwr=%b m=%b v=%b want 1/10/0", cr_wr, match, c_valid); end
        apply('0, 1'b1);
        wr_pulses += int'(cr_wr);
        n_checks++; if (wr_pulses !== 1) begin n_fails++; $display("FAIL suppress_once got %0d writes want 1", wr_pulses); end
        n_checks++; if (stall_cnt !== 32'd5) begin n_fails++; $display("FAIL stall_cnt5 got %0d want 5", stall_cnt); end
    endtask

    task automatic test_boundaries;
        apply(mk(32'h00FF_0000, 32'h0, 1'b1, 1'b0), 1'b1);
        n_checks++; if ({cr_wr, vga_wr, match} !== 4'b0101) begin
            n_fails++; $display("FAIL bnd_cr_top got crwr=%b vgawr=%b m=%b want 0/1/01", cr_wr, vga_wr, match); end
        apply(mk(32'h0100_0000, 32'h0, 1'b0, 1'b1), 1'b1);
        n_checks++; if ({c_valid, vga_rd, match, ready} !== 5'b10001) begin
            n_fails++; $display("FAIL bnd_vga_top got v=%b vgard=%b m=%b rdy=%b want 1/0/00/1", c_valid, vga_rd, match, ready); end
        apply(mk(32'h00FD_FFFF, 32'h0, 1'b0, 1'b1), 1'b1);
        n_checks++; if ({c_valid, cr_rd, match} !== 4'b1000) begin
            n_fails++; $display("FAIL bnd_below_cr got v=%b crrd=%b m=%b want 1/0/00", c_valid, cr_rd, match); end
        apply(mk(32'h00FE_0000, 32'h0, 1'b0, 1'b1), 1'b1);
        n_checks++; if ({c_valid, cr_rd, match} !== 4'b0110) begin
            n_fails++; $display("FAIL bnd_cr_base got v=%b crrd=%b m=%b want 0/1/10", c_valid, cr_rd, match); end
        apply(mk(32'h00FE_FFFF, 32'h0, 1'b0, 1'b1), 1'b1);
        n_checks++; if ({cr_rd, vga_rd} !== 2'b10) begin
            n_fails++; $display("FAIL bnd_cr_last got crrd=%b vgard=%b want 1/0", cr_rd, vga_rd); end
        apply(mk(32'h00FF_FFFF, 32'h0, 1'b0, 1'b1), 1'b1);
        n_checks++; if ({cr_rd, vga_rd} !== 2'b01) begin
            n_fails++; $display("FAIL bnd_vga_last got crrd=%b vgard=%b want 0/1", cr_rd, vga_rd); end
        apply('0, 1'b1);
        n_checks++; if (stall_cnt !== 32'd5) begin n_fails++; $display("FAIL bnd_no_stall got %0d want 5", stall_cnt); end
    endtask

    task automatic test_timeout;
        t_core2mem_req rd;
        int low_cycles;
        rd = mk(32'h0000_3000, 32'h0, 1'b0, 1'b1);
        low_cycles = 0;
        for (int i = 0; i < 1024; i++) begin
            apply(rd, 1'b0);
            low_cycles += int'(!ready);
            if (i == 1023) begin
                n_checks++; if (timeout !== 1'b0) begin
                    n_fails++; $display("FAIL timeout_early got %b want 0 after 1023 stalls", timeout); end
            end
        end
        n_checks++; if (low_cycles !== 1024) begin n_fails++; $display("FAIL timeout_low_cycles got %0d want 1024", low_cycles); end
        apply(rd, 1'b1);
        n_checks++; if (timeout !== 1'b1 || ready !== 1'b1) begin
            n_fails++; $display("FAIL timeout_set got to=%b rdy=%b want 1/1", timeout, ready); end
        apply('0, 1'b1);
        apply('0, 1'b1);
        n_checks++; if (timeout !== 1'b1) begin n_fails++; $display("FAIL timeout_sticky got %b want 1", timeout); end
        n_checks++; if (stall_cnt !== 32'd1029) begin n_fails++; $display("FAIL stall_cnt1029 got %0d want 1029", stall_cnt); end
    endtask

    task automatic test_reset_mid_stall;
        t_core2mem_req rd;
        rd = mk(32'h0000_4000, 32'h0, 1'b0, 1'b1);
        apply(rd, 1'b0);
        apply(rd, 1'b0);
        n_checks++; if (ready !== 1'b0 || c_valid !== 1'b1) begin
            n_fails++; $display("FAIL rst_pre_stall got rdy=%b v=%b want 0/1", ready, c_valid); end
        #2;
        req = '0;
        Rst = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b1 || c_valid !== 1'b0 || c_req !== '0) begin
            n_fails++; $display("FAIL rst_async_idle got rdy=%b v=%b req=%h want 1/0/0", ready, c_valid, c_req); end
        n_checks++; if ({cr_wr, cr_rd, vga_wr, vga_rd, match} !== 6'b0) begin
            n_fails++; $display("FAIL rst_strobes got %b want 0", {cr_wr, cr_rd, vga_wr, vga_rd, match}); end
        n_checks++; if (stall_cnt !== 32'd0 || timeout !== 1'b0) begin
            n_fails++; $display("FAIL rst_counters got cnt=%0d to=%b want 0/0", stall_cnt, timeout); end
        @(negedge Clock);
        Rst = 1'b0;
        apply(mk(32'h00FE_0008, 32'h0, 1'b1, 1'b0), 1'b0);
        n_checks++; if (cr_wr !== 1'b1 || ready !== 1'b1 || c_valid !== 1'b0) begin
            n_fails++; $display("FAIL rst_resume got crwr=%b rdy=%b v=%b want 1/1/0", cr_wr, ready, c_valid); end
        apply('0, 1'b1);
        n_checks++; if (stall_cnt !== 32'd0) begin n_fails++; $display("FAIL rst_resume_cnt got %0d want 0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_cr_write();
        test_vga_read();
        test_cache_stall();
        test_stall_suppress();
        test_boundaries();
        test_timeout();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
